// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and the memory side (slave).
interface ifu_fetch_ctrl_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one ibus request at a
// time, kills stale responses after redirects and buffers fetched words
// (with their PCs) in a small FIFO towards decode.
// Optional macro IFU_FETCH_PERF_EN adds push/kill event counters.
//
// state | meaning
// IDLE  | no request outstanding; launch one when the FIFO has room
// REQ   | request presented on ibus, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// KILL  | accepted request made stale by a redirect; drop its data
module ifu_fetch_ctrl #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ifu_fetch_ctrl_if.master      ibus,
  input  logic                  i_redirect_valid,
  input  logic [63:0]           i_redirect_pc,
  input  logic                  i_dec_ready,
  output logic                  o_inst_valid,
  output logic [63:0]           o_inst_pc,
  output logic [31:0]           o_inst,
  output logic                  o_busy
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_fetch,
  output logic [31:0]           o_perf_kill
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_KILL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [63:0]     r_fpc;
  logic [63:0]     w_fpc_nxt;
  logic            w_req_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_kill;
  logic            w_room;
  logic [CW-1:0]   w_occ;

  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [63:0]     r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_inst [DEPTH];

  // An in-flight request reserves a FIFO slot so its data can always be pushed.
  assign w_occ  = r_count + {{PW{1'b0}}, (r_state != ST_IDLE)};
  assign w_room = w_occ < CW'(DEPTH);
  assign w_pop  = o_inst_valid & i_dec_ready & ~i_redirect_valid;

  // State and fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
    end
  end

  // Next state, fetch PC update and push/kill decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_req_valid = 1'b0;
    w_push      = 1'b0;
    w_kill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_room) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_req_valid = 1'b1;
        if (ibus.iresp_addr_ok) w_state_nxt = i_redirect_valid ? ST_KILL : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_redirect_valid) begin
          if (ibus.iresp_data_ok) begin
            w_kill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_KILL;
          end
        end else if (ibus.iresp_data_ok) begin
          w_push      = 1'b1;
          w_fpc_nxt   = r_fpc + 64'd4;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KILL: begin
        if (ibus.iresp_data_ok) begin
          w_kill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A redirect always wins the fetch PC, whatever the state.
    if (i_redirect_valid) w_fpc_nxt = i_redirect_pc;
  end

  // FIFO pointers and occupancy; redirect flushes ahead of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible while the entry is counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fpc;
      r_mem_inst[r_wr_ptr] <= ibus.iresp_data;
    end
  end

  assign ibus.ireq_valid = w_req_valid;
  assign ibus.ireq_addr  = r_fpc;
  assign o_inst_valid    = (r_count != '0);
  assign o_inst_pc       = o_inst_valid ? r_mem_pc[r_rd_ptr]   : 64'd0;
  assign o_inst          = o_inst_valid ? r_mem_inst[r_rd_ptr] : 32'd0;
  assign o_busy          = (r_state != ST_IDLE);

`ifdef IFU_FETCH_PERF_EN
  // Event counters; they survive redirects and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_fetch <= '0;
      o_perf_kill  <= '0;
    end else begin
      if (w_push) o_perf_fetch <= o_perf_fetch + 32'd1;
      if (w_kill) o_perf_kill  <= o_perf_kill + 32'd1;
    end
  end
`else
  logic w_unused_kill;
  assign w_unused_kill = w_kill;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: inputs change on the falling edge,
// outputs are checked on the falling edge (all outputs are register-derived).
module tb_ifu_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic        busy;
  int          checks;
  int          errors;

  ifu_fetch_ctrl_if ibus ();

  ifu_fetch_ctrl #(.DEPTH(2), .RESET_PC(64'h8000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ibus             (ibus),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_dec_ready      (dec_ready),
    .o_inst_valid     (inst_valid),
    .o_inst_pc        (inst_pc),
    .o_inst           (inst),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    dec_ready = 1'b0;
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b0;
    ibus.iresp_data = 32'd0;
    tick(); tick();
    chk("rst_ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    // T1: IDLE for one cycle, then request at RESET_PC
    tick();
    chk("t1_req_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    chk("t1_req_addr", ibus.ireq_addr, 64'h8000_0000);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    ibus.iresp_addr_ok = 1'b1;
    tick();
    chk("t1_wait_req_low", {63'd0, ibus.ireq_valid}, 64'd0);
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'h0000_0013;
    tick();
    ibus.iresp_data_ok = 1'b0;
    chk("t1_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("t1_inst_pc", inst_pc, 64'h8000_0000);
    chk("t1_inst", {32'd0, inst}, 64'h13);
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);
    // T2: dec_ready low, second fetch fills the FIFO
    tick();
    chk("t2_req2_addr", ibus.ireq_addr, 64'h8000_0004);
    chk("t2_req2_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    ibus.iresp_addr_ok = 1'b1;
    tick();
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'h0000_0017;
    tick();
    ibus.iresp_data_ok = 1'b0;
    chk("t2_head_pc_kept", inst_pc, 64'h8000_0000);
    tick();
    chk("t2_full_no_req", {63'd0, ibus.ireq_valid}, 64'd0);
    tick();
    chk("t2_full_no_req2", {63'd0, ibus.ireq_valid}, 64'd0);
    chk("t2_full_busy", {63'd0, busy}, 64'd0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("t2_pop_pc", inst_pc, 64'h8000_0004);
    chk("t2_pop_inst", {32'd0, inst}, 64'h17);
    tick();
    chk("t2_resume_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    chk("t2_resume_addr", ibus.ireq_addr, 64'h8000_0008);
    // T4: redirect with data_ok, FIFO holding one entry
    ibus.iresp_addr_ok = 1'b1;
    tick();
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'h0000_AAAA;
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    ibus.iresp_data_ok = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_flush_valid", {63'd0, inst_valid}, 64'd0);
    chk("t4_flush_pc", inst_pc, 64'd0);
    chk("t4_idle", {63'd0, busy}, 64'd0);
    tick();
    chk("t4_req_addr", ibus.ireq_addr, 64'h2000);
    chk("t4_req_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    // T5: redirect while REQ, not accepted
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    chk("t5_req_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    chk("t5_req_addr", ibus.ireq_addr, 64'h3000);
    ibus.iresp_addr_ok = 1'b1;
    tick();
    ibus.iresp_addr_ok = 1'b0;
    chk("t5_wait_not_kill", {63'd0, ibus.ireq_valid}, 64'd0);
    // T3: redirect in WAIT, stale data later
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    chk("t3_kill_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("t3_kill_hold", {63'd0, busy}, 64'd1);
    chk("t3_kill_no_req", {63'd0, ibus.ireq_valid}, 64'd0);
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'hDEAD_BEEF;
    tick();
    ibus.iresp_data_ok = 1'b0;
    chk("t3_dropped", {63'd0, inst_valid}, 64'd0);
    chk("t3_idle", {63'd0, busy}, 64'd0);
    tick();
    chk("t3_req_addr", ibus.ireq_addr, 64'h8000_1000);
    // fpc+4 wraps to zero
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req_addr", ibus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ibus.iresp_addr_ok = 1'b1;
    tick();
    ibus.iresp_addr_ok = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'h0000_0055;
    tick();
    ibus.iresp_data_ok = 1'b0;
    chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_inst", {32'd0, inst}, 64'h55);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("wrap_popped", {63'd0, inst_valid}, 64'd0);
    chk("wrap_next_addr", ibus.ireq_addr, 64'd0);
    // unaligned redirect target passes through
    redirect_valid = 1'b1;
    redirect_pc = 64'h1003;
    tick();
    redirect_valid = 1'b0;
    chk("lowbits_addr", ibus.ireq_addr, 64'h1003);
    ibus.iresp_addr_ok = 1'b1;
    tick();
    ibus.iresp_addr_ok = 1'b0;
    chk("t6_in_wait", {63'd0, busy}, 64'd1);
    // T6: reset mid-transaction, data_ok during and after reset
    rst_n = 1'b0;
    ibus.iresp_data_ok = 1'b1;
    ibus.iresp_data = 32'h0000_0099;
    #1;
    chk("t6_async_busy", {63'd0, busy}, 64'd0);
    chk("t6_async_req", {63'd0, ibus.ireq_valid}, 64'd0);
    tick();
    chk("t6_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    rst_n = 1'b1;
    tick();
    ibus.iresp_data_ok = 1'b0;
    chk("t6_no_push", {63'd0, inst_valid}, 64'd0);
    chk("t6_restart_valid", {63'd0, ibus.ireq_valid}, 64'd1);
    chk("t6_restart_addr", ibus.ireq_addr, 64'h8000_0000);
    tick();
    chk("t6_still_empty", {63'd0, inst_valid}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
